// File: rtl/kyber_loader_pkg.sv
// kyber_loader_pkg: loader FSM states, ciphertext word counts per Kyber rank and k->N helpers.
package kyber_loader_pkg;
    typedef enum logic [2:0] {
        ST_IDLE, ST_CRST, ST_ARM, ST_LOAD, ST_STREAM, ST_WAIT_OUT, ST_DONE
    } state_e;
    localparam logic [8:0] CT_WORDS_K2 = 9'd192;
    localparam logic [8:0] CT_WORDS_K3 = 9'd272;
    localparam logic [8:0] CT_WORDS_K4 = 9'd392;
    function automatic logic k_legal(input logic [2:0] k);
        return k inside {3'd2, 3'd3, 3'd4};
    endfunction
    function automatic logic [8:0] ct_words(input logic [2:0] k);
        return k == 3'd2 ? CT_WORDS_K2 : k == 3'd3 ? CT_WORDS_K3 : k == 3'd4 ? CT_WORDS_K4 : 9'd0;
    endfunction
endpackage

// File: rtl/kyber_ct_streamer.sv
// kyber_ct_streamer: issues ciphertext RAM addresses 0..N-1 and aligns write enables with
// the one-cycle RAM read latency; last_o marks the final aligned write.
module kyber_ct_streamer #(
    parameter int pDW = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_i,
    input  logic [8:0]     n_i,
    input  logic [pDW-1:0] ct_data_i,
    output logic [8:0]     ct_addr_o,
    output logic           wen_o,
    output logic [pDW-1:0] din_o,
    output logic           last_o
);
    logic       issue_q, issue_d, wen_q, last_q, at_end;
    logic [8:0] addr_q, addr_d;
    assign at_end = issue_q && addr_q == n_i - 9'd1;
    always_comb begin
        issue_d = start_i | (issue_q & ~at_end);
        addr_d  = issue_q && !at_end ? addr_q + 9'd1 : 9'd0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_q <= 1'b0;
            addr_q  <= 9'd0;
            wen_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            issue_q <= issue_d;
            addr_q  <= addr_d;
            wen_q   <= issue_q;
            last_q  <= at_end;
        end
    end
    // Data returned this cycle belongs to the address issued last cycle.
    assign ct_addr_o = addr_q;
    assign wen_o     = wen_q;
    assign din_o     = wen_q ? ct_data_i : '0;
    assign last_o    = last_q;
endmodule

// File: rtl/kyber_ct_loader.sv
// kyber_ct_loader: resets/starts a Kyber decaps core, streams the ciphertext into it and collects
// the shared secret. Optional WAIT_OUT watchdog is enabled by defining KYBER_LOADER_TIMEOUT_EN.
module kyber_ct_loader
    import kyber_loader_pkg::*;
#(
    parameter int pDW       = 32,
    parameter int pSS_WORDS = 8,
    parameter int pTIMEOUT  = 65535
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_i,
    input  logic [2:0]                   k_i,
    output logic [8:0]                   ct_addr_o,
    input  logic [pDW-1:0]               ct_data_i,
    output logic [$clog2(pSS_WORDS)-1:0] ss_addr_o,
    output logic [pDW-1:0]               ss_data_o,
    output logic                         ss_we_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o,
    output logic                         core_rst_o,
    output logic                         core_start_o,
    output logic                         core_ready_c_o,
    output logic                         core_wen_o,
    output logic [2:0]                   core_k_o,
    output logic [pDW-1:0]               core_din_o,
    input  logic                         core_req_c_i,
    input  logic                         core_valid_i,
    input  logic [pDW-1:0]               core_dout_i
);
    localparam int AW = $clog2(pSS_WORDS);
    state_e        state_q, state_d;
    logic [2:0]    k_q, k_d;
    logic          err_q, err_d;
    logic [AW-1:0] ss_cnt_q, ss_cnt_d;
    logic          strm_start, strm_last, ss_last, to_hit, to_rst;
    kyber_ct_streamer #(.pDW(pDW)) u_streamer (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (strm_start),
        .n_i       (ct_words(k_q)),
        .ct_data_i (ct_data_i),
        .ct_addr_o (ct_addr_o),
        .wen_o     (core_wen_o),
        .din_o     (core_din_o),
        .last_o    (strm_last)
    );
    assign ss_we_o = state_q == ST_WAIT_OUT && core_valid_i;
    assign ss_last = ss_we_o && ss_cnt_q == AW'(pSS_WORDS - 1);
`ifdef KYBER_LOADER_TIMEOUT_EN
    localparam int TW = $clog2(pTIMEOUT + 1);
    logic [TW-1:0] to_cnt_q;
    logic          to_rst_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            to_rst_q <= 1'b0;
        end else begin
            to_cnt_q <= state_q == ST_WAIT_OUT ? to_cnt_q + TW'(1) : '0;
            to_rst_q <= to_hit;
        end
    end
    // Completion in the same cycle as expiry wins over the timeout.
    assign to_hit = state_q == ST_WAIT_OUT && !ss_last && to_cnt_q == TW'(pTIMEOUT - 1);
    assign to_rst = to_rst_q;
`else
    assign to_hit = 1'b0;
    assign to_rst = 1'b0;
`endif
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        err_d      = err_q;
        strm_start = 1'b0;
        ss_cnt_d   = state_q != ST_WAIT_OUT ? '0 : ss_last ? '0 : ss_we_o ? ss_cnt_q + AW'(1) : ss_cnt_q;
        case (state_q)
            ST_IDLE: if (start_i) begin
                if (k_legal(k_i)) begin
                    state_d = ST_CRST;
                    k_d     = k_i;
                    err_d   = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end
            ST_CRST:   state_d = ST_ARM;
            ST_ARM:    state_d = ST_LOAD;
            ST_LOAD: if (core_req_c_i) begin
                state_d    = ST_STREAM;
                strm_start = 1'b1;
            end
            ST_STREAM: if (strm_last) state_d = ST_WAIT_OUT;
            ST_WAIT_OUT: begin
                if (ss_last) begin
                    state_d = ST_DONE;
                end else if (to_hit) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            k_q      <= 3'd0;
            err_q    <= 1'b0;
            ss_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            err_q    <= err_d;
            ss_cnt_q <= ss_cnt_d;
        end
    end
    assign ss_addr_o      = ss_cnt_q;
    assign ss_data_o      = ss_we_o ? core_dout_i : '0;
    assign busy_o         = state_q != ST_IDLE;
    assign done_o         = state_q == ST_DONE;
    assign err_o          = err_q;
    assign core_rst_o     = !rst_n || state_q == ST_CRST || to_rst;
    assign core_start_o   = state_q == ST_ARM;
    assign core_ready_c_o = state_q inside {ST_LOAD, ST_STREAM, ST_WAIT_OUT};
    assign core_k_o       = k_q;
endmodule
